// File: rtl/rca_ft_param.sv
// Fault-tolerant ripple-carry adder: WIDTH slices plus one spare, with BIST and single-fault remap.
// Optional RCA_FT_OUTREG_EN registers s/cout (latency 1); default build is combinational.
module rca_ft_param #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          ST_ON_INIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         init,
    input  logic                         start_test,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         cin,
    input  logic [WIDTH:0]               fi_sum,
    input  logic [WIDTH:0]               fi_cy,
    output logic [WIDTH-1:0]             s,
    output logic                         cout,
    output logic                         busy,
    output logic                         done,
    output logic                         fault_det,
    output logic [$clog2(WIDTH+1)-1:0]   fault_idx,
    output logic                         uncorrectable
);

    localparam int unsigned IW = $clog2(WIDTH + 1);
    localparam int          NS = WIDTH + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TEST   = 2'd1;
    localparam logic [1:0] ST_CONFIG = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    pat_q, pat_d;
    logic [NS-1:0] fail_q, fail_d;
    logic          auto_q, auto_d;
    logic          fault_det_q, fault_det_d;
    logic [IW-1:0] fault_idx_q, fault_idx_d;
    logic          unc_q, unc_d;
    logic          remap_q, remap_d;

    logic [NS-1:0]    slice_err;
    logic [WIDTH-1:0] sum_int;
    logic             cout_int;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    // Slice array: each physical slice is fed either from the logical operands (IDLE, mapped)
    // or from the shared test pattern with its carry-in isolated (TEST).
    always_comb begin
        logic          carry, ai, bi, ci, sv, cv, active, gold_s, gold_c;
        logic [IW-1:0] kk, li;
        logic [NS-1:0] a_ext, b_ext;
        a_ext     = {1'b0, a};
        b_ext     = {1'b0, b};
        sum_int   = '0;
        slice_err = '0;
        carry     = cin;
        gold_s    = ^pat_q;
        gold_c    = (pat_q[2] & pat_q[1]) | (pat_q[0] & (pat_q[2] ^ pat_q[1]));
        for (int k = 0; k < NS; k++) begin
            kk = IW'(k);
            if (remap_q) begin
                active = (kk != fault_idx_q);
            end else begin
                active = (kk != IW'(WIDTH));
            end
            active = active && (state_q == ST_IDLE);
            li = (remap_q && (kk > fault_idx_q)) ? kk - IW'(1) : kk;
            if (active) begin
                ai = a_ext[li];
                bi = b_ext[li];
                ci = carry;
            end else if (state_q == ST_TEST) begin
                ai = pat_q[2];
                bi = pat_q[1];
                ci = pat_q[0];
            end else begin
                ai = 1'b0;
                bi = 1'b0;
                ci = 1'b0;
            end
            sv = ai ^ bi ^ ci ^ fi_sum[k];
            cv = (ai & bi) | (ci & (ai ^ bi)) | fi_cy[k];
            if (active) begin
                carry   = cv;
                sum_int = sum_int | (WIDTH'(sv) << li);
            end
            slice_err[k] = (sv != gold_s) || (cv != gold_c);
        end
        cout_int = carry;
    end

    always_comb begin
        logic [IW-1:0] low;
        logic          multi;
        state_d     = state_q;
        pat_d       = pat_q;
        fail_d      = fail_q;
        auto_d      = 1'b0;
        fault_det_d = fault_det_q;
        fault_idx_d = fault_idx_q;
        unc_d       = unc_q;
        remap_d     = remap_q;
        low         = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (fail_q[k]) low = IW'(k);
        end
        multi = |(fail_q & (fail_q - NS'(1)));
        case (state_q)
            ST_IDLE: begin
                if (start_test || (ST_ON_INIT && auto_q)) begin
                    state_d = ST_TEST;
                    pat_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_TEST: begin
                fail_d = fail_q | slice_err;
                pat_d  = pat_q + 3'd1;
                if (pat_q == 3'd7) state_d = ST_CONFIG;
            end
            ST_CONFIG: begin
                fault_det_d = |fail_q;
                fault_idx_d = low;
                unc_d       = multi;
                // A lone failing spare needs no remap.
                remap_d     = (|fail_q) && !multi && (low != IW'(WIDTH));
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            fail_q      <= '0;
            auto_q      <= 1'b1;
            fault_det_q <= 1'b0;
            fault_idx_q <= '0;
            unc_q       <= 1'b0;
            remap_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            fail_q      <= fail_d;
            auto_q      <= auto_d;
            fault_det_q <= fault_det_d;
            fault_idx_q <= fault_idx_d;
            unc_q       <= unc_d;
            remap_q     <= remap_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_CONFIG);
    assign fault_det     = fault_det_q;
    assign fault_idx     = fault_idx_q;
    assign uncorrectable = unc_q;

    always_comb begin
        s_d    = busy ? '0 : sum_int;
        cout_d = busy ? 1'b0 : cout_int;
    end

`ifdef RCA_FT_OUTREG_EN
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    always_ff @(posedge clk) begin
        if (init) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
`else
    assign s    = s_d;
    assign cout = cout_d;
`endif

endmodule
